// File: rtl/core_pkg.sv
// Shared definitions for the core's UART input path: default bit timing and RX FSM encoding.
package core_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam int UART_FIFO_AW_DEFAULT      = 4;

    typedef enum logic [2:0] {
        RX_ARM   = 3'd0,
        RX_IDLE  = 3'd1,
        RX_START = 3'd2,
        RX_DATA  = 3'd3,
        RX_STOP  = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer on rx, then a bit-timed FSM producing one-cycle
// byte_valid / frame_err pulses. rx_state is the live FSM state for observation.
module uart_rx_byte
    import core_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           rx,
    output logic           byte_valid,
    output logic [7:0]     byte_data,
    output logic           frame_err,
    output uart_rx_state_t rx_state
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    uart_rx_state_t state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronizer resets to the idle (high) level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= RX_ARM;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_ARM: begin
                    // Require a full bit time of idle line before listening for a start bit.
                    if (!rx_sync) begin
                        timer <= '0;
                    end else if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= RX_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_IDLE: begin
                    if (!rx_sync) begin
                        timer <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_ARM;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= RX_ARM;
                end
            endcase
        end
    end

    assign rx_state = state;

endmodule

// File: rtl/uart_input_word_buffer.sv
// UART input word buffer: packs received bytes big-endian into 32-bit words and queues them in a
// first-word-fall-through FIFO for the write-back stage.
module uart_input_word_buffer
    import core_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_AW      = UART_FIFO_AW_DEFAULT
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               rx,
    input  logic               input_ack,
    output logic               input_ready,
    output logic [31:0]        input_data,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overrun,
    output logic               frame_error,
    output uart_rx_state_t     rx_state
);

    // Handshake: input_ready is a valid flag for input_data; a cycle with input_ack=1 and
    // input_ready=1 consumes the head word, input_ack while input_ready=0 is ignored.

    localparam int DEPTH = 1 << FIFO_AW;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err_pulse;

    logic [1:0]       byte_cnt;
    logic [23:0]      pack;
    logic [31:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;

    logic             empty;
    logic             full;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic [31:0]      push_word;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK        (CLK),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err_pulse),
        .rx_state   (rx_state)
    );

    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_count == (FIFO_AW+1)'(DEPTH));
    assign push_req   = byte_valid && (byte_cnt == 2'd3);
    assign push_word  = {pack, byte_data};
    assign pop        = input_ack && !empty;
    // When full, a same-cycle pop frees the head slot, which is exactly the slot being written.
    assign push_ok    = push_req && (!full || pop);

    always_ff @(posedge CLK) begin
        if (reset) begin
            byte_cnt <= '0;
            pack     <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            pack     <= {pack[15:0], byte_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overrun <= 1'b1;
            end
            if (frame_err_pulse) begin
                frame_error <= 1'b1;
            end
        end
    end

    assign input_ready = !empty;
    assign input_data  = empty ? 32'h0 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_uart_input_word_buffer.sv
// Directed bench for uart_input_word_buffer with an 8-cycle bit time and a 4-word FIFO.
module tb_uart_input_word_buffer;
    import core_pkg::*;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic           CLK;
    logic           reset;
    logic           rx;
    logic           input_ack;
    logic           input_ready;
    logic [31:0]    input_data;
    logic [AW:0]    fifo_count;
    logic           overrun;
    logic           frame_error;
    uart_rx_state_t rx_state;

    int errors;
    int checks;

    uart_input_word_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .rx         (rx),
        .input_ack  (input_ack),
        .input_ready(input_ready),
        .input_data (input_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_error(frame_error),
        .rx_state   (rx_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // One 8N1 frame driven on negedges; ack_last raises input_ack on the final cycle of the
    // stop bit, the cycle in which the receiver's byte_valid reaches the FIFO.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic ack_last);
        rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = stop_bit;
        repeat (CPB - 1) @(negedge CLK);
        input_ack = ack_last;
        @(negedge CLK);
        input_ack = 1'b0;
        idle(2);
    endtask

    task automatic send_word(input logic [31:0] w, input logic ack_last);
        send_byte(w[31:24], 1'b1, 1'b0);
        send_byte(w[23:16], 1'b1, 1'b0);
        send_byte(w[15:8],  1'b1, 1'b0);
        send_byte(w[7:0],   1'b1, ack_last);
    endtask

    task automatic pop_one();
        input_ack = 1'b1;
        @(negedge CLK);
        input_ack = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        rx        = 1'b1;
        input_ack = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("rst_ready", {31'd0, input_ready}, 32'd0);
        check("rst_data", input_data, 32'h0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        idle(12);

        send_word(32'h12345678, 1'b0);
        check("w1_ready", {31'd0, input_ready}, 32'd1);
        check("w1_data", input_data, 32'h12345678);
        check("w1_count", {29'd0, fifo_count}, 32'd1);

        pop_one();
        check("ack_ready", {31'd0, input_ready}, 32'd0);
        check("ack_count", {29'd0, fifo_count}, 32'd0);
        pop_one();
        check("ack_empty_count", {29'd0, fifo_count}, 32'd0);
        check("ack_empty_ready", {31'd0, input_ready}, 32'd0);

        send_word(32'hA1A2A3A4, 1'b0);
        send_word(32'hB1B2B3B4, 1'b0);
        send_word(32'hC1C2C3C4, 1'b0);
        send_word(32'hD1D2D3D4, 1'b0);
        check("fill_overrun_clear", {31'd0, overrun}, 32'd0);
        send_word(32'hE1E2E3E4, 1'b0);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_overrun", {31'd0, overrun}, 32'd1);
        check("full_head", input_data, 32'hA1A2A3A4);

        send_word(32'hF1F2F3F4, 1'b1);
        check("pushpop_count", {29'd0, fifo_count}, 32'd4);
        check("pushpop_head", input_data, 32'hB1B2B3B4);
        pop_one();
        check("drain_c", input_data, 32'hC1C2C3C4);
        pop_one();
        check("drain_d", input_data, 32'hD1D2D3D4);
        pop_one();
        check("drain_f", input_data, 32'hF1F2F3F4);
        pop_one();
        check("drain_count", {29'd0, fifo_count}, 32'd0);

        send_byte(8'hA5, 1'b0, 1'b0);
        idle(16);
        check("ferr_flag", {31'd0, frame_error}, 32'd1);
        check("ferr_count", {29'd0, fifo_count}, 32'd0);
        send_word(32'h0BADF00D, 1'b0);
        check("ferr_next_count", {29'd0, fifo_count}, 32'd1);
        check("ferr_next_data", input_data, 32'h0BADF00D);
        pop_one();

        rx = 1'b0;
        repeat (2) @(negedge CLK);
        idle(20);
        check("glitch_count", {29'd0, fifo_count}, 32'd0);
        send_word(32'hCAFEBABE, 1'b0);
        check("glitch_next_count", {29'd0, fifo_count}, 32'd1);
        check("glitch_next_data", input_data, 32'hCAFEBABE);

        rx = 1'b0;
        repeat (CPB * 3) @(negedge CLK);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("midrst_count", {29'd0, fifo_count}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_frame_error", {31'd0, frame_error}, 32'd0);
        check("midrst_data", input_data, 32'h0);
        idle(12);
        send_word(32'h89ABCDEF, 1'b0);
        check("midrst_word_count", {29'd0, fifo_count}, 32'd1);
        check("midrst_word_data", input_data, 32'h89ABCDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
